// File: rtl/dna_pkg.sv
// Shared definitions for the device-DNA reader: identifier width and sequencer states.
package dna_pkg;

    localparam int DNA_W     = 57;
    localparam int BIT_CNT_W = $clog2(DNA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/dna_clk_gen.sv
// Slow DNA_PORT clock: DIV clk cycles low, DIV high, with sample/end-of-high strobes.
module dna_clk_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic suppress,
    output logic dna_clk,
    output logic smp,
    output logic end_hi
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] phase_q, phase_d;
    logic       hi_q, hi_d;
    logic       clk_q, clk_d;
    logic       wrap;

    assign wrap    = run && (phase_q == LAST);
    assign smp     = wrap && !hi_q;
    assign end_hi  = wrap && hi_q;
    assign dna_clk = clk_q;

    // hi_q tracks the logical half-period even while the pin is suppressed,
    // so end_hi still fires after a swallowed rising edge.
    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        clk_d   = clk_q;
        if (!run) begin
            phase_d = 8'd0;
            hi_d    = 1'b0;
            clk_d   = 1'b0;
        end else if (wrap) begin
            phase_d = 8'd0;
            hi_d    = !hi_q;
            clk_d   = !hi_q && !suppress;
        end else begin
            phase_d = phase_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 8'd0;
            hi_q    <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            clk_q   <= clk_d;
        end
    end

endmodule

// File: rtl/dna_reader.sv
// Reads the 57-bit device identifier out of DNA_PORT serially (MSB first) and
// presents it in parallel; dna is meaningful only while dna_vld is high.
module dna_reader
    import dna_pkg::*;
#(
    parameter int DIV  = 4,
    parameter bit AUTO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [DNA_W-1:0] dna,
    output logic             dna_vld,
    output logic             dna_clk,
    output logic             dna_read,
    output logic             dna_shift,
    input  logic             dna_dout,
    output state_e           dbg_state
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DNA_W - 1);
    localparam logic [BIT_CNT_W-1:0] ALL_BITS = BIT_CNT_W'(DNA_W);

    state_e               state_q, state_d;
    logic                 auto_q, auto_d;
    logic                 busy_q, busy_d;
    logic                 vld_q, vld_d;
    logic                 read_q, read_d;
    logic                 shift_q, shift_d;
    logic [DNA_W-1:0]     dna_q, dna_d;
    logic [DNA_W-1:0]     sr_q, sr_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;

    logic run, suppress, smp, end_hi;

    assign run      = (state_q == LOAD) || (state_q == SHIFT);
    // The last sample coincides with what would be the 57th rising edge; hold the pin low.
    assign suppress = (state_q == SHIFT) && smp && (bit_q == LAST_BIT);

    dna_clk_gen #(
        .DIV(DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .suppress(suppress),
        .dna_clk (dna_clk),
        .smp     (smp),
        .end_hi  (end_hi)
    );

    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        busy_d  = busy_q;
        vld_d   = vld_q;
        read_d  = read_q;
        shift_d = shift_q;
        dna_d   = dna_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d = LOAD;
                    auto_d  = 1'b0;
                    busy_d  = 1'b1;
                    vld_d   = 1'b0;
                    read_d  = 1'b1;
                end
            end
            LOAD: begin
                if (end_hi) begin
                    state_d = SHIFT;
                    read_d  = 1'b0;
                    shift_d = 1'b1;
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                if (smp) begin
                    sr_d  = {sr_q[DNA_W-2:0], dna_dout};
                    bit_d = bit_q + BIT_CNT_W'(1);
                    if (bit_q == LAST_BIT) begin
                        shift_d = 1'b0;
                    end
                end
                if (end_hi && (bit_q == ALL_BITS)) begin
                    state_d = DONE;
                    dna_d   = sr_q;
                    vld_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    vld_d   = 1'b0;
                    read_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            auto_q  <= AUTO;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            read_q  <= 1'b0;
            shift_q <= 1'b0;
            dna_q   <= '0;
            sr_q    <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            read_q  <= read_d;
            shift_q <= shift_d;
            dna_q   <= dna_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
        end
    end

    assign busy      = busy_q;
    assign dna       = dna_q;
    assign dna_vld   = vld_q;
    assign dna_read  = read_q;
    assign dna_shift = shift_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dna_reader.sv
// Bench for dna_reader: three instances (DIV=4 AUTO=1, DIV=4 AUTO=0, DIV=1 AUTO=0)
// each driven by a behavioural DNA_PORT model.
module tb_dna_reader;
    import dna_pkg::*;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  start;
    logic [2:0]  busy, dna_vld, dna_clk, dna_read, dna_shift, dna_dout;
    logic [56:0] dna_o [3];
    state_e      dbg_state [3];

    logic [56:0] mdl_val [3];
    logic [56:0] mdl_sr [3] = '{default: '0};
    logic [2:0]  clk_prev = '0;
    int          rise_cnt [3] = '{default: 0};
    int          shift_rise [3] = '{default: 0};
    logic [56:0] last_dna [3] = '{default: '0};

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int          inst;
        logic [56:0] val;
        int          dup_at;
        int          exp_lat;
    } vec_t;
    vec_t vecs [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    dna_reader #(.DIV(4), .AUTO(1'b1)) u_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .dna(dna_o[0]),
        .dna_vld(dna_vld[0]), .dna_clk(dna_clk[0]), .dna_read(dna_read[0]),
        .dna_shift(dna_shift[0]), .dna_dout(dna_dout[0]), .dbg_state(dbg_state[0]));
    dna_reader #(.DIV(4), .AUTO(1'b0)) u_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .dna(dna_o[1]),
        .dna_vld(dna_vld[1]), .dna_clk(dna_clk[1]), .dna_read(dna_read[1]),
        .dna_shift(dna_shift[1]), .dna_dout(dna_dout[1]), .dbg_state(dbg_state[1]));
    dna_reader #(.DIV(1), .AUTO(1'b0)) u_c (
        .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .dna(dna_o[2]),
        .dna_vld(dna_vld[2]), .dna_clk(dna_clk[2]), .dna_read(dna_read[2]),
        .dna_shift(dna_shift[2]), .dna_dout(dna_dout[2]), .dbg_state(dbg_state[2]));

    // DNA_PORT model: loads on a rising CLK with READ, shifts left on a rising CLK with SHIFT.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dna_clk[i] && !clk_prev[i]) begin
                rise_cnt[i] <= rise_cnt[i] + 1;
                if (dna_read[i]) begin
                    mdl_sr[i] <= mdl_val[i];
                end else if (dna_shift[i]) begin
                    mdl_sr[i]     <= {mdl_sr[i][55:0], 1'b0};
                    shift_rise[i] <= shift_rise[i] + 1;
                end
            end
            clk_prev[i] <= dna_clk[i];
        end
    end

    assign dna_dout = {mdl_sr[2][56], mdl_sr[1][56], mdl_sr[0][56]};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One complete read; expectations come from the identifier loaded and the DIV timing rules.
    task automatic run_read(input int i, input int div, input logic [56:0] val, input int exp_lat,
                            input int dup_at, input bit use_start, input string tag);
        int n, rd_cyc, sh_cyc, wave_err, hold_err, r0, s0, wave_end;
        bit done, exp_clk;
        wave_end = (DNA_W + 1) * 2 * div - div;
        mdl_val[i] = val;
        r0 = rise_cnt[i];
        s0 = shift_rise[i];
        if (use_start) start[i] = 1'b1;
        else rst[i] = 1'b0;
        @(negedge clk);
        start[i] = 1'b0;
        check({tag, "_busy"}, busy[i], 64'd1);
        check({tag, "_vld_lo"}, dna_vld[i], 64'd0);
        n = 0; rd_cyc = 0; sh_cyc = 0; wave_err = 0; hold_err = 0; done = 1'b0;
        while (!done && n <= exp_lat + 50) begin
            exp_clk = (n < wave_end) && ((n % (2 * div)) >= div);
            if (dna_clk[i] !== exp_clk) wave_err++;
            if (dna_o[i] !== last_dna[i]) hold_err++;
            if (dna_read[i]) rd_cyc++;
            if (dna_shift[i]) sh_cyc++;
            start[i] = (n == dup_at);
            @(negedge clk);
            n++;
            done = dna_vld[i];
        end
        start[i] = 1'b0;
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_dna"}, dna_o[i], val);
        check({tag, "_wave_err"}, wave_err, 0);
        check({tag, "_hold_err"}, hold_err, 0);
        check({tag, "_read_cyc"}, rd_cyc, 2 * div);
        check({tag, "_shift_cyc"}, sh_cyc, wave_end - 2 * div);
        check({tag, "_rises"}, rise_cnt[i] - r0, DNA_W);
        check({tag, "_shift_rises"}, shift_rise[i] - s0, DNA_W - 1);
        check({tag, "_busy_end"}, busy[i], 64'd0);
        check({tag, "_clk_done"}, dna_clk[i], 64'd0);
        last_dna[i] = val;
    endtask

    initial begin
        logic [63:0] rnd;
        int          div, gap;
        rst   = 3'b111;
        start = 3'b000;
        for (int i = 0; i < 3; i++) mdl_val[i] = '0;

        vecs[0] = '{inst: 1, val: 57'h000000000000000, dup_at: -1,  exp_lat: 464};
        vecs[1] = '{inst: 1, val: 57'h155555555555555, dup_at: 300, exp_lat: 464};
        vecs[2] = '{inst: 2, val: 57'h000000000000001, dup_at: -1,  exp_lat: 116};
        vecs[3] = '{inst: 2, val: 57'h100000000000000, dup_at: 50,  exp_lat: 116};
        vecs[4] = '{inst: 2, val: 57'h0AAAAAAAAAAAAAA, dup_at: -1,  exp_lat: 116};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ctl%0d", i), {busy[i], dna_vld[i], dna_clk[i], dna_read[i], dna_shift[i]}, 64'd0);
            check($sformatf("rst_dna%0d", i), dna_o[i], 64'd0);
            check($sformatf("rst_state%0d", i), dbg_state[i], IDLE);
        end

        // start coincident with reset on the DIV=1 instance must not begin a read
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        rst[2] = 1'b0;
        rst[1] = 1'b0;
        repeat (30) @(negedge clk);
        for (int i = 1; i < 3; i++) begin
            check($sformatf("noauto_ctl%0d", i), {busy[i], dna_vld[i], dna_clk[i], dna_read[i]}, 64'd0);
        end

        run_read(0, 4, 57'h0823456789ABCDE, 464, -1, 1'b0, "a_auto");
        run_read(0, 4, 57'h1FFFFFFFFFFFFFF, 464, 100, 1'b1, "a_restart");

        // reset in the middle of the shift phase (bit counter near 30)
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (250) @(negedge clk);
        check("a_mid_busy", busy[0], 64'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        check("a_abort_ctl", {busy[0], dna_vld[0], dna_clk[0], dna_read[0], dna_shift[0]}, 64'd0);
        check("a_abort_dna", dna_o[0], 64'd0);
        last_dna[0] = '0;
        rnd = {$urandom, $urandom};
        run_read(0, 4, rnd[56:0], 464, -1, 1'b0, "a_after_rst");

        for (int k = 0; k < 5; k++) begin
            div = (vecs[k].inst == 2) ? 1 : 4;
            run_read(vecs[k].inst, div, vecs[k].val, vecs[k].exp_lat, vecs[k].dup_at, 1'b1,
                     $sformatf("vec%0d", k));
        end

        for (int k = 0; k < 4; k++) begin
            gap = $urandom_range(0, 20);
            repeat (gap) @(negedge clk);
            check($sformatf("rnd%0d_hold", k), dna_o[1], last_dna[1]);
            check($sformatf("rnd%0d_vld", k), dna_vld[1], 64'd1);
            rnd = {$urandom, $urandom};
            run_read(1, 4, rnd[56:0], 2 * 4 + DNA_W * 2 * 4, $urandom_range(1, 450), 1'b1,
                     $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
